// File: rtl/signed_add_arbiter_if.sv
// Handshake bundle between the requesting datapath units and signed_add_arbiter:
// per-requester operand-pair valid/ready plus the registered response channel.
interface signed_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_ovf;
  logic [ID_W-1:0]          rsp_id;

  // Requester/consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id
  );
endinterface

// File: rtl/signed_add_arbiter.sv
// Round-robin arbiter sharing one signed WIDTH-bit adder among NUM_REQ requesters.
// Optional macro SADD_SAT_EN: saturate overflowing sums instead of wrapping.
module signed_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst,
  signed_add_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, winner, rsp_id_q;
  logic             found;
  logic [WIDTH-1:0] win_a, win_b, op_a, op_b;
  logic [WIDTH-1:0] sum, result, rsp_data_q;
  logic             ovf, rsp_ovf_q, rsp_valid_q;

  // Round-robin search: indices at or above ptr first, then the wrapped ones.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && bus.req_valid[j] && (ID_W'(j) >= ptr)) begin
        found  = 1'b1;
        winner = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && bus.req_valid[j] && (ID_W'(j) < ptr)) begin
        found  = 1'b1;
        winner = ID_W'(j);
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == ID_W'(j)) begin
        win_a = bus.req_a[j*WIDTH +: WIDTH];
        win_b = bus.req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      bus.req_ready[j] = !rst && (state == IDLE) && found && (winner == ID_W'(j));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shared adder; carry-out is dropped and overflow comes from the sign bits.
  always_comb begin
    sum = op_a + op_b;
    ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
`ifdef SADD_SAT_EN
    if (ovf) result = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else     result = sum;
`else
    result = sum;
`endif
  end

  // NOTE: the operand latches are pure datapath and are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      op_a <= win_a;
      op_b <= win_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          rsp_id_q <= winner;
          ptr      <= (winner == LAST_ID) ? '0 : winner + 1'b1;
        end
        EXEC: begin
          rsp_data_q  <= result;
          rsp_ovf_q   <= ovf;
          rsp_valid_q <= 1'b1;
        end
        RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed bench for signed_add_arbiter: vector table through single requesters,
// then round-robin order, backpressure and mid-operation reset sequences.
module tb_signed_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signed_add_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  signed_add_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  function automatic logic [31:0] onehot(input int i);
    logic [31:0] v;
    v = 32'd0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]         = v;
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'd1010, 32'd1000, 32'd2010, 1'b0};
    vecs[1] = '{1, -32'sd1001253, -32'sd263784, -32'sd1265037, 1'b0};
    vecs[2] = '{2, 32'sd263, -32'sd27383, -32'sd27120, 1'b0};
    vecs[3] = '{3, -32'sd2526393, 32'sd5363, -32'sd2521030, 1'b0};
    vecs[4] = '{0, 32'sd25263, -32'sd536336, -32'sd511073, 1'b0};
`ifdef SADD_SAT_EN
    vecs[5] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
    vecs[6] = '{2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7] = '{3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1};
`else
    vecs[5] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
    vecs[6] = '{2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    vecs[7] = '{3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
`endif
    vecs[8] = '{0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with a request pending to show req_ready is forced low.
    set_req(0, 1'b1, 32'd7, 32'd8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    check("reset_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Table vectors: grant at T, EXEC at T+1, response at T+2, IDLE at T+3.
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1 set_req(vecs[k].req, 1'b1, vecs[k].a, vecs[k].b);
      @(negedge clk);
      check($sformatf("v%0d_req_ready", k), 32'(bus.req_ready), onehot(vecs[k].req));
      @(posedge clk);
      #1 set_req(vecs[k].req, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
      @(negedge clk);
      check($sformatf("v%0d_exec_rsp_valid", k), 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("v%0d_rsp_data", k), bus.rsp_data, vecs[k].exp_data);
      check($sformatf("v%0d_rsp_ovf", k), 32'(bus.rsp_ovf), 32'(vecs[k].exp_ovf));
      check($sformatf("v%0d_rsp_id", k), 32'(bus.rsp_id), 32'(vecs[k].req));
    end

    // Round-robin fairness from a fresh reset, all requesters valid.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 begin
      rst = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'(i * 100 + 5), 32'(i * 3));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d_req_ready", k), 32'(bus.req_ready), onehot(k % NUM_REQ));
      @(negedge clk);
      @(negedge clk);
      check($sformatf("rr%0d_rsp_id", k), 32'(bus.rsp_id), 32'(k % NUM_REQ));
      check($sformatf("rr%0d_rsp_data", k), bus.rsp_data, 32'((k % NUM_REQ) * 103 + 5));
    end
    @(posedge clk);
    #1 bus.req_valid = '0;

    // Backpressure: ptr is now 1; requester 2 alone, then hold in RESP.
    @(posedge clk);
    #1 begin
      bus.rsp_ready = 1'b0;
      set_req(2, 1'b1, 32'hFFFF_FFF0, 32'h0000_0020);
    end
    @(negedge clk);
    check("bp_req_ready", 32'(bus.req_ready), onehot(2));
    @(posedge clk);
    #1 begin
      set_req(2, 1'b0, 32'd0, 32'd0);
      set_req(0, 1'b1, 32'd1, 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_rsp_data", bus.rsp_data, 32'h0000_0010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", c), bus.rsp_data, 32'h0000_0010);
      check($sformatf("bp_hold%0d_id", c), 32'(bus.rsp_id), 32'd2);
      check($sformatf("bp_hold%0d_ovf", c), 32'(bus.rsp_ovf), 32'd0);
      check($sformatf("bp_hold%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1 begin
      bus.rsp_ready = 1'b1;
      bus.req_valid = '0;
    end
    @(negedge clk);
    check("bp_release_valid_same_cycle", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    check("bp_release_valid_next_cycle", 32'(bus.rsp_valid), 32'd0);

    // Reset in EXEC: ptr is 3; grant requester 1 (ptr would become 2).
    @(posedge clk);
    #1 set_req(1, 1'b1, 32'd50, 32'd60);
    @(negedge clk);
    check("rst_grant_req_ready", 32'(bus.req_ready), onehot(1));
    @(posedge clk);
    #1 begin
      set_req(1, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;
    end
    @(negedge clk);
    check("rst_req_ready_forced_low", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_no_rsp%0d", c), 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1 for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'd11, 32'd22);
    @(negedge clk);
    check("rst_next_grant", 32'(bus.req_ready), onehot(0));
    @(negedge clk);
    @(negedge clk);
    check("rst_next_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_next_rsp_data", bus.rsp_data, 32'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
